// File: rtl/fp8_dot_accum_if.sv
// Stream bundle for the FP8 dot-product accumulator: product beats in,
// one FP8 result (plus raw accumulator and clamp flag) out per vector.
interface fp8_dot_accum_if #(
  parameter int ACC_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [ACC_W-1:0] out_acc;
  logic             out_sat;

  // Upstream multiplier stage / downstream consumer side.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_acc, out_sat
  );

  // Accumulator side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_acc, out_sat
  );
endinterface

// File: rtl/fp8_dot_accum.sv
// Streaming FP8 E4M3 accumulator: sums products exactly in a signed
// fixed-point register (units of 2^-9) and emits one truncated, saturated
// FP8 result per vector over a valid/ready handshake.
module fp8_dot_accum #(
  parameter int MAX_LEN = 16,
  parameter int ACC_W   = 24
) (
  input logic           clk,
  input logic           rst_n,
  fp8_dot_accum_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int PW    = $clog2(ACC_W);

  localparam logic [1:0] ACCUM = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic [7:0]       out_data_r;
  logic [ACC_W-1:0] out_acc_r;
  logic             out_sat_r;

  logic [3:0]       in_exp;
  logic [2:0]       in_mant;
  logic [17:0]      mag;
  logic [ACC_W-1:0] mag_ext;
  logic [ACC_W-1:0] val;
  logic [ACC_W:0]   sum;
  logic             ovf_pos;
  logic             ovf_neg;
  logic [ACC_W-1:0] next_acc;

  logic [ACC_W-1:0] abs_acc;
  logic [PW-1:0]    lead;
  logic [7:0]       enc_data;
  logic             enc_clamp;

  assign in_exp  = bus.in_data[6:3];
  assign in_mant = bus.in_data[2:0];

  // Decode the incoming FP8 product into a signed fixed-point value.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    mag = '0;
    if (in_exp == 4'd0) mag = {15'd0, in_mant};
    else                mag = {14'd0, 1'b1, in_mant} << (in_exp - 4'd1);
    mag_ext = ACC_W'(mag);
    val     = bus.in_data[7] ? (~mag_ext + 1'b1) : mag_ext;
  end

  // One-bit-wider add detects leaving the signed range; clamp symmetrically.
  always_comb begin
    sum      = {acc[ACC_W-1], acc} + {val[ACC_W-1], val};
    ovf_pos  = !sum[ACC_W] &&  sum[ACC_W-1];
    ovf_neg  =  sum[ACC_W] && !sum[ACC_W-1];
    next_acc = sum[ACC_W-1:0];
    if (ovf_pos)      next_acc = ACC_MAX;
    else if (ovf_neg) next_acc = ACC_MIN;
  end

  // Encode |acc| to FP8 by leading-one position, truncating the mantissa.
  always_comb begin
    abs_acc   = acc[ACC_W-1] ? (~acc + 1'b1) : acc;
    lead      = '0;
    enc_data  = 8'h00;
    enc_clamp = 1'b0;
    for (int i = 0; i < ACC_W; i++) begin
      if (abs_acc[i]) lead = PW'(i);
    end
    if (abs_acc == '0) begin
      enc_data = 8'h00;
    end else if (lead >= PW'(18)) begin
      enc_data  = {acc[ACC_W-1], 7'h7F};
      enc_clamp = 1'b1;
    end else if (lead <= PW'(2)) begin
      enc_data = {acc[ACC_W-1], 4'd0, abs_acc[2:0]};
    end else begin
      enc_data = {acc[ACC_W-1], 4'(lead - PW'(2)), 3'(abs_acc >> (lead - PW'(3)))};
    end
  end

  // Control FSM, accumulator and registered result.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state      <= ACCUM;
      acc        <= '0;
      cnt        <= '0;
      sat        <= 1'b0;
      out_data_r <= 8'h00;
      out_acc_r  <= '0;
      out_sat_r  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.in_valid) begin
            acc <= next_acc;
            sat <= sat | ovf_pos | ovf_neg;
            cnt <= cnt + CNT_W'(1);
            if (bus.in_last || (cnt == LAST_CNT)) state <= NORM;
          end
        end
        NORM: begin
          out_data_r <= enc_data;
          out_acc_r  <= acc;
          out_sat_r  <= sat | enc_clamp;
          state      <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_data  = out_data_r;
  assign bus.out_acc   = out_acc_r;
  assign bus.out_sat   = out_sat_r;
endmodule

// File: tb/tb_fp8_dot_accum.sv
// Self-checking bench for fp8_dot_accum: directed scenarios plus randomized
// vectors compared against an arithmetic reference model.
module tb_fp8_dot_accum;
  localparam int MAX_LEN = 16;
  localparam int ACC_W   = 24;

  typedef logic [7:0] beat_q_t [$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  fp8_dot_accum_if #(.ACC_W(ACC_W)) bus ();

  fp8_dot_accum #(.MAX_LEN(MAX_LEN), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: exact integer sum with range clamp, then FP8 by binade search.
  function automatic void model(input beat_q_t q, output logic [7:0] d,
                                output logic [ACC_W-1:0] a, output bit s);
    longint acc = 0;
    longint lim = (longint'(1) << (ACC_W - 1)) - 1;
    longint v, m;
    bit neg;
    s = 0;
    foreach (q[i]) begin
      int e  = int'(q[i][6:3]);
      int mt = int'(q[i][2:0]);
      v = (e == 0) ? longint'(mt) : longint'(8 + mt) * (longint'(1) << (e - 1));
      if (q[i][7]) v = -v;
      acc += v;
      if (acc > lim) begin acc = lim; s = 1; end
      else if (acc < -lim - 1) begin acc = -lim; s = 1; end
    end
    a   = acc[ACC_W-1:0];
    neg = (acc < 0);
    m   = neg ? -acc : acc;
    if (m == 0) d = 8'h00;
    else if (m >= 262144) begin d = {neg, 7'h7F}; s = 1; end
    else if (m < 8) d = {neg, 4'd0, m[2:0]};
    else begin
      d = 8'h00;
      for (int e = 1; e <= 15; e++) begin
        longint base = longint'(8) << (e - 1);
        if (m >= base && m < 2 * base) begin
          longint mm = m / (longint'(1) << (e - 1)) - 8;
          d = {neg, 4'(e), mm[2:0]};
        end
      end
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      bus.in_valid = 1'b0;
      bus.in_last  = 1'($urandom_range(0, 1));
      bus.in_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.in_last = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit last);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && t < 50) begin @(negedge clk); t++; end
    if (!bus.in_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: in_ready=%0b required 1", bus.in_ready);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_vec(input beat_q_t q, input bit use_last, input bit gaps);
    foreach (q[i]) begin
      if (gaps) idle($urandom_range(0, 2));
      send(q[i], use_last && (i == q.size() - 1));
    end
  endtask

  task automatic get_result(input string name, input logic [7:0] ed,
                            input logic [ACC_W-1:0] ea, input bit es);
    int t = 0;
    while (!bus.out_valid && t < 20) begin @(negedge clk); t++; end
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s out_valid timeout: got %b required 1", name, bus.out_valid);
      return;
    end
    vectors++;
    if (bus.out_data !== ed) begin
      miscompares++;
      $display("FAIL %s out_data: got %h required %h", name, bus.out_data, ed);
    end
    vectors++;
    if (bus.out_acc !== ea) begin
      miscompares++;
      $display("FAIL %s out_acc: got %0d required %0d", name, $signed(bus.out_acc), $signed(ea));
    end
    vectors++;
    if (bus.out_sat !== es) begin
      miscompares++;
      $display("FAIL %s out_sat: got %b required %b", name, bus.out_sat, es);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s release: out_valid=%b in_ready=%b required 0/1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic check_vec(input string name, input beat_q_t q);
    logic [7:0] d; logic [ACC_W-1:0] a; bit s;
    model(q, d, a, s);
    send_vec(q, 1'b1, 1'b0);
    get_result(name, d, a, s);
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 8'h00 ||
        bus.out_acc !== '0 || bus.out_sat !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: out_valid=%b in_ready=%b out_data=%h out_acc=%0d out_sat=%b required 0 1 00 0 0",
               name, bus.out_valid, bus.in_ready, bus.out_data, bus.out_acc, bus.out_sat);
    end
  endtask

  task automatic pulse_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
  endtask

  task automatic test_basic();
    send(8'h38, 1'b0);
    send(8'h38, 1'b1);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_norm: out_valid=%b in_ready=%b required 0/0", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_latency: out_valid=%b required 1", bus.out_valid);
    end
    get_result("basic", 8'h40, 24'd1024, 1'b0);
  endtask

  task automatic test_subnormal_cancel();
    check_vec("subnormal", '{8'h01, 8'h01, 8'h01});
    get_result_dummy_guard();
    check_vec("cancel", '{8'h38, 8'hB8});
  endtask

  // Ensures no stray result is pending between back-to-back directed vectors.
  task automatic get_result_dummy_guard();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stray_result: out_valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_trunc_sat();
    send(8'h38, 1'b0); send(8'h01, 1'b1);
    get_result("trunc", 8'h38, 24'd513, 1'b0);
    send(8'h7F, 1'b0); send(8'h7F, 1'b1);
    get_result("fp8_sat_pos", 8'h7F, 24'd491520, 1'b1);
    send(8'hFF, 1'b0); send(8'hFF, 1'b1);
    get_result("fp8_sat_neg", 8'hFF, 24'(-491520), 1'b1);
  endtask

  task automatic test_len_cap();
    repeat (MAX_LEN) send(8'h38, 1'b0);
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL len_cap_ready: in_ready=%b required 0", bus.in_ready);
    end
    get_result("len_cap", 8'h58, 24'd8192, 1'b0);
    send(8'h38, 1'b1);
    get_result("len_cap_next", 8'h38, 24'd512, 1'b0);
    repeat (MAX_LEN - 1) send(8'h38, 1'b0);
    send(8'h38, 1'b1);
    get_result("len_and_last", 8'h58, 24'd8192, 1'b0);
    get_result_dummy_guard();
    send(8'h40, 1'b1);
    get_result("after_len_and_last", 8'h40, 24'd1024, 1'b0);
  endtask

  task automatic test_backpressure();
    send(8'h38, 1'b0); send(8'h38, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 8'h7F; bus.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== 8'h40 ||
          bus.out_acc !== 24'd1024) begin
        miscompares++;
        $display("FAIL hold_%0d: out_valid=%b in_ready=%b out_data=%h out_acc=%0d required 1 0 40 1024",
                 i, bus.out_valid, bus.in_ready, bus.out_data, bus.out_acc);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
    send(8'h7F, 1'b1);
    get_result("after_hold", 8'h7F, 24'd245760, 1'b0);
  endtask

  task automatic test_reset_mid();
    int t = 0;
    send(8'h38, 1'b0); send(8'h41, 1'b0); send(8'h05, 1'b0);
    pulse_reset();
    check_reset_outputs("reset_mid_vector");
    send(8'h40, 1'b1);
    get_result("after_reset_mid", 8'h40, 24'd1024, 1'b0);
    send(8'h38, 1'b1);
    while (!bus.out_valid && t < 20) begin @(negedge clk); t++; end
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_hold_setup: out_valid=%b required 1", bus.out_valid);
    end
    pulse_reset();
    check_reset_outputs("reset_in_hold");
    send(8'h40, 1'b1);
    get_result("after_reset_hold", 8'h40, 24'd1024, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      beat_q_t q;
      int len = $urandom_range(1, MAX_LEN);
      bit use_last = (len < MAX_LEN) ? 1'b1 : 1'($urandom_range(0, 1));
      logic [7:0] d; logic [ACC_W-1:0] a; bit s;
      q = {};
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) q.push_back({1'($urandom), 7'h7F});
        else q.push_back(8'($urandom));
      end
      model(q, d, a, s);
      send_vec(q, use_last, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      get_result($sformatf("random_%0d", n), d, a, s);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_subnormal_cancel();
    test_trunc_sat();
    test_len_cap();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
